// File: rtl/rt_pulse_train_gen.sv
// rt_pulse_train_gen: emits N pulses of H' cycles separated by L' idle cycles, then a done strobe
module rt_pulse_train_gen #(
   parameter int NUM_BIT = 32
) (
   input  logic               rt_i_clk,
   input  logic               rt_i_rst_n,
   input  logic               rt_i_start,
   input  logic               rt_i_abort,
   input  logic [NUM_BIT-1:0] rt_i_num,
   input  logic [NUM_BIT-1:0] rt_i_high,
   input  logic [NUM_BIT-1:0] rt_i_low,
   output logic               rt_o_pulse,
   output logic               rt_o_busy,
   output logic               rt_o_done,
   output logic [NUM_BIT-1:0] rt_o_remain
);
   typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;
   localparam logic [NUM_BIT-1:0] ONE = {{(NUM_BIT-1){1'b0}}, 1'b1};
   state_t st, st_n;
   logic [NUM_BIT-1:0] hi, hi_n, lo, lo_n, phase, phase_n, remain, remain_n;
   // next-state and datapath update; abort overrides everything outside IDLE
   always_comb begin
      st_n     = st;
      hi_n     = hi;
      lo_n     = lo;
      phase_n  = phase;
      remain_n = remain;
      case (st)
         IDLE: if (rt_i_start && !rt_i_abort) begin
            hi_n     = (rt_i_high == '0) ? ONE : rt_i_high;
            lo_n     = (rt_i_low == '0) ? ONE : rt_i_low;
            remain_n = rt_i_num;
            phase_n  = hi_n - ONE;
            st_n     = (rt_i_num == '0) ? DONE : HIGH;
         end
         HIGH: if (phase == '0) begin
            remain_n = (remain == '0) ? '0 : remain - ONE;
            st_n     = (remain <= ONE) ? DONE : LOW;
            phase_n  = lo - ONE;
         end else
            phase_n = phase - ONE;
         LOW: if (phase == '0) begin
            st_n    = HIGH;
            phase_n = hi - ONE;
         end else
            phase_n = phase - ONE;
         DONE: st_n = IDLE;
         default: st_n = IDLE;
      endcase
      if (rt_i_abort && st != IDLE) begin
         st_n     = IDLE;
         remain_n = '0;
      end
   end
   // state and latched operands, cleared immediately on reset
   always_ff @(posedge rt_i_clk or negedge rt_i_rst_n) begin
      if (!rt_i_rst_n) begin
         st     <= IDLE;
         hi     <= '0;
         lo     <= '0;
         phase  <= '0;
         remain <= '0;
      end else begin
         st     <= st_n;
         hi     <= hi_n;
         lo     <= lo_n;
         phase  <= phase_n;
         remain <= remain_n;
      end
   end
   assign rt_o_pulse  = (st == HIGH);
   assign rt_o_busy   = (st == HIGH) || (st == LOW);
   assign rt_o_done   = (st == DONE);
   assign rt_o_remain = remain;
endmodule
